// File: rtl/mpmc11_pkg.sv
// mpmc11_pkg: controller and watchdog state types shared by the mpmc11 watchdog.
package mpmc11_pkg;
    typedef enum logic [2:0] {IDLE, ACT, RD, WR, PRE, REF} mpmc11_state_t;
    typedef enum logic [1:0] {WD_IDLE, WD_COUNT, WD_HOLD} mpmc11_wd_state_t;
    localparam int MPMC11_TO_LIMIT_DEF = 512;
endpackage

// File: rtl/mpmc11_sat_cnt.sv
// mpmc11_sat_cnt: saturating up-counter with synchronous clear.
module mpmc11_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) q <= '0;
        else q <= clr ? '0 : (inc && q != '1) ? q + 1'b1 : q;
    end
endmodule

// File: rtl/mpmc11_state_watchdog.sv
// mpmc11_state_watchdog: flags controller states that dwell too long, with
// retry counting, abort escalation and a saturating total timeout count.
module mpmc11_state_watchdog
    import mpmc11_pkg::*;
#(
    parameter int CNT_WIDTH = 16,
    parameter int TO_LIMIT  = MPMC11_TO_LIMIT_DEF,
    parameter int MAX_RETRY = 3,
    parameter int HOLD_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  mpmc11_state_t        state,
    input  mpmc11_state_t        prev_state,
    input  logic                 ack,
    output logic [CNT_WIDTH-1:0] to_cnt,
    output logic                 to_pulse,
    output logic                 to_sticky,
    output mpmc11_state_t        to_state,
    output logic [1:0]           retry_cnt,
    output logic                 to_abort,
    output logic [15:0]          to_total
);
    if (TO_LIMIT < 1 || 64'(TO_LIMIT) >= (64'd1 << CNT_WIDTH) || MAX_RETRY < 1 || MAX_RETRY > 3) begin : g_bad_param
        $error("mpmc11_state_watchdog: illegal TO_LIMIT/CNT_WIDTH/MAX_RETRY");
    end

    mpmc11_wd_state_t     wd_state, wd_n;
    logic [CNT_WIDTH-1:0] cnt_n;
    logic [1:0]           retry_n;
    logic                 stay, chg, te;

    assign stay = state == prev_state && state != IDLE;
    assign chg  = state != prev_state && state != IDLE;
    assign te   = en && stay && to_cnt == CNT_WIDTH'(TO_LIMIT) && wd_state == WD_COUNT;

    // IDLE and state changes take priority over a coincident timeout
    always_comb begin
        wd_n    = wd_state;
        cnt_n   = to_cnt;
        retry_n = retry_cnt;
        if (state == IDLE) begin
            wd_n    = WD_IDLE;
            cnt_n   = '0;
            retry_n = '0;
        end else if (chg) begin
            wd_n    = WD_COUNT;
            cnt_n   = '0;
            retry_n = '0;
        end else if (te) begin
            wd_n    = (HOLD_MODE != 0) ? WD_HOLD : WD_COUNT;
            cnt_n   = (HOLD_MODE != 0) ? to_cnt : '0;
            retry_n = (retry_cnt == 2'(MAX_RETRY)) ? retry_cnt : retry_cnt + 2'd1;
        end else if (en && wd_state == WD_COUNT) begin
            cnt_n = to_cnt + 1'b1;
        end else if (en && wd_state == WD_IDLE) begin
            wd_n = WD_COUNT;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wd_state  <= WD_IDLE;
            to_cnt    <= '0;
            retry_cnt <= '0;
            to_pulse  <= 1'b0;
            to_sticky <= 1'b0;
            to_abort  <= 1'b0;
            to_state  <= IDLE;
        end else begin
            wd_state  <= wd_n;
            to_cnt    <= cnt_n;
            retry_cnt <= retry_n;
            to_pulse  <= te;
            to_sticky <= te | (to_sticky & ~ack);
            to_abort  <= (te && retry_cnt == 2'(MAX_RETRY - 1)) | (to_abort & ~ack);
            if (te && (!to_sticky || ack)) to_state <= state;
        end
    end

    mpmc11_sat_cnt #(.W(16)) u_total (
        .clk (clk),
        .rstn(rstn),
        .clr (1'b0),
        .inc (te),
        .q   (to_total)
    );
endmodule

// File: tb/tb_mpmc11_state_watchdog.sv
// tb_mpmc11_state_watchdog: checks HOLD_MODE 0/1 instances at TO_LIMIT=8 and a default instance.
module tb_mpmc11_state_watchdog;
    import mpmc11_pkg::*;

    typedef struct {
        logic [15:0] cnt;
        logic        pulse;
        logic [1:0]  retry;
        logic        abort;
    } exp_t;

    logic clk = 1'b0, rstn, en, ack;
    mpmc11_state_t state, prev_state;
    logic [15:0] cnt0, cnt1, cntd, tot0, tot1, totd;
    logic pul0, pul1, puld, stk0, stk1, stkd, ab0, ab1, abd;
    logic [1:0] rt0, rt1, rtd;
    mpmc11_state_t ts0, ts1, tsd;
    exp_t q0[$], q1[$], qd[$];
    int passed = 0, total = 0;

    always #5 clk = ~clk;

    mpmc11_state_watchdog #(.TO_LIMIT(8), .MAX_RETRY(3), .HOLD_MODE(0)) u0 (
        .clk(clk), .rstn(rstn), .en(en), .state(state), .prev_state(prev_state), .ack(ack),
        .to_cnt(cnt0), .to_pulse(pul0), .to_sticky(stk0), .to_state(ts0), .retry_cnt(rt0),
        .to_abort(ab0), .to_total(tot0));
    mpmc11_state_watchdog #(.TO_LIMIT(8), .MAX_RETRY(3), .HOLD_MODE(1)) u1 (
        .clk(clk), .rstn(rstn), .en(en), .state(state), .prev_state(prev_state), .ack(ack),
        .to_cnt(cnt1), .to_pulse(pul1), .to_sticky(stk1), .to_state(ts1), .retry_cnt(rt1),
        .to_abort(ab1), .to_total(tot1));
    mpmc11_state_watchdog ud (
        .clk(clk), .rstn(rstn), .en(en), .state(state), .prev_state(prev_state), .ack(ack),
        .to_cnt(cntd), .to_pulse(puld), .to_sticky(stkd), .to_state(tsd), .retry_cnt(rtd),
        .to_abort(abd), .to_total(totd));

    task automatic cyc(input mpmc11_state_t s);
        prev_state = state;
        state = s;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rstn = 1'b0; en = 1'b1; ack = 1'b0; state = IDLE; prev_state = IDLE;
        repeat (2) @(posedge clk);
        #1;
        total++; if (cnt0 !== 16'd0) $display("FAIL reset_cnt got %0d want 0", cnt0); else passed++;
        total++; if (pul0 !== 1'b0 || stk0 !== 1'b0 || ab0 !== 1'b0) $display("FAIL reset_flags got %b%b%b want 000", pul0, stk0, ab0); else passed++;
        total++; if (ts0 !== IDLE || rt0 !== 2'd0 || tot0 !== 16'd0) $display("FAIL reset_misc got %0d/%0d/%0d want 0/0/0", ts0, rt0, tot0); else passed++;
        rstn = 1'b1;
        cyc(IDLE);
        total++; if (cnt0 !== 16'd0 || pul0 !== 1'b0) $display("FAIL idle_after_reset got %0d/%b want 0/0", cnt0, pul0); else passed++;
    endtask

    task automatic test_wrap;
        exp_t e;
        cyc(ACT);
        total++; if (cnt0 !== 16'd0) $display("FAIL entry_cnt got %0d want 0", cnt0); else passed++;
        for (int k = 1; k <= 30; k++) begin
            q0.push_back('{cnt: 16'(k % 9), pulse: (k % 9 == 0), retry: 2'((k / 9 > 3) ? 3 : k / 9), abort: (k >= 27)});
            q1.push_back('{cnt: 16'((k > 8) ? 8 : k), pulse: (k == 9), retry: 2'(k >= 9), abort: 1'b0});
            qd.push_back('{cnt: 16'(k), pulse: 1'b0, retry: 2'd0, abort: 1'b0});
            cyc(ACT);
            e = q0.pop_front();
            total++; if (cnt0 !== e.cnt || pul0 !== e.pulse) $display("FAIL wrap0_k%0d got %0d/%b want %0d/%b", k, cnt0, pul0, e.cnt, e.pulse); else passed++;
            total++; if (rt0 !== e.retry || ab0 !== e.abort) $display("FAIL retry0_k%0d got %0d/%b want %0d/%b", k, rt0, ab0, e.retry, e.abort); else passed++;
            e = q1.pop_front();
            total++; if (cnt1 !== e.cnt || pul1 !== e.pulse || rt1 !== e.retry) $display("FAIL hold1_k%0d got %0d/%b/%0d want %0d/%b/%0d", k, cnt1, pul1, rt1, e.cnt, e.pulse, e.retry); else passed++;
            e = qd.pop_front();
            total++; if (cntd !== e.cnt || puld !== e.pulse) $display("FAIL dflt_k%0d got %0d/%b want %0d/%b", k, cntd, puld, e.cnt, e.pulse); else passed++;
        end
        total++; if (tot0 !== 16'd3 || rt0 !== 2'd3 || ab0 !== 1'b1) $display("FAIL wrap_summary got %0d/%0d/%b want 3/3/1", tot0, rt0, ab0); else passed++;
        total++; if (stk0 !== 1'b1 || ts0 !== ACT) $display("FAIL wrap_sticky got %b/%0d want 1/%0d", stk0, ts0, ACT); else passed++;
        total++; if (tot1 !== 16'd1 || ab1 !== 1'b0 || stk1 !== 1'b1) $display("FAIL hold_summary got %0d/%b/%b want 1/0/1", tot1, ab1, stk1); else passed++;
    endtask

    task automatic test_hold_exit;
        cyc(RD);
        total++; if (cnt1 !== 16'd0 || rt1 !== 2'd0) $display("FAIL hold_exit got %0d/%0d want 0/0", cnt1, rt1); else passed++;
        cyc(RD);
        total++; if (cnt1 !== 16'd1 || cnt0 !== 16'd1) $display("FAIL hold_recount got %0d/%0d want 1/1", cnt1, cnt0); else passed++;
    endtask

    task automatic test_ack_te;
        repeat (7) cyc(RD);
        total++; if (cnt0 !== 16'd8) $display("FAIL pre_ack_cnt got %0d want 8", cnt0); else passed++;
        ack = 1'b1;
        cyc(RD);
        total++; if (pul0 !== 1'b1 || stk0 !== 1'b1) $display("FAIL ack_te_sticky got %b/%b want 1/1", pul0, stk0); else passed++;
        total++; if (ts0 !== RD || ab0 !== 1'b0) $display("FAIL ack_te_state got %0d/%b want %0d/0", ts0, ab0, RD); else passed++;
        cyc(RD);
        total++; if (stk0 !== 1'b0 || pul0 !== 1'b0 || cnt0 !== 16'd1) $display("FAIL ack_clear got %b/%b/%0d want 0/0/1", stk0, pul0, cnt0); else passed++;
        ack = 1'b0;
    endtask

    task automatic test_change_at_limit;
        repeat (7) cyc(RD);
        total++; if (cnt0 !== 16'd8) $display("FAIL pre_change_cnt got %0d want 8", cnt0); else passed++;
        cyc(WR);
        total++; if (pul0 !== 1'b0 || cnt0 !== 16'd0 || rt0 !== 2'd0) $display("FAIL change_at_limit got %b/%0d/%0d want 0/0/0", pul0, cnt0, rt0); else passed++;
        total++; if (tot0 !== 16'd4 || stk0 !== 1'b0) $display("FAIL change_total got %0d/%b want 4/0", tot0, stk0); else passed++;
        cyc(WR);
        total++; if (pul0 !== 1'b0 || cnt0 !== 16'd1) $display("FAIL change_next got %b/%0d want 0/1", pul0, cnt0); else passed++;
    endtask

    task automatic test_enable;
        repeat (3) cyc(WR);
        total++; if (cnt0 !== 16'd4) $display("FAIL en_pre got %0d want 4", cnt0); else passed++;
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(WR);
            total++; if (cnt0 !== 16'd4 || pul0 !== 1'b0) $display("FAIL en_hold_%0d got %0d/%b want 4/0", i, cnt0, pul0); else passed++;
        end
        en = 1'b1;
        repeat (2) cyc(WR);
        total++; if (cnt0 !== 16'd6) $display("FAIL en_resume got %0d want 6", cnt0); else passed++;
        rstn = 1'b0;
        #1;
        total++; if (cnt0 !== 16'd0 || pul0 !== 1'b0 || rt0 !== 2'd0) $display("FAIL async_rst_cnt got %0d/%b/%0d want 0/0/0", cnt0, pul0, rt0); else passed++;
        total++; if (ts0 !== IDLE || tot0 !== 16'd0 || ab0 !== 1'b0 || stk0 !== 1'b0) $display("FAIL async_rst_flags got %0d/%0d/%b/%b want 0/0/0/0", ts0, tot0, ab0, stk0); else passed++;
        rstn = 1'b1;
        en = 1'b0;
        cyc(WR);
        cyc(WR);
        total++; if (cnt0 !== 16'd0) $display("FAIL post_rst_no_en got %0d want 0", cnt0); else passed++;
        en = 1'b1;
    endtask

    task automatic test_default;
        exp_t e;
        cyc(ACT);
        for (int k = 1; k <= 514; k++) begin
            qd.push_back('{cnt: 16'(k % 513), pulse: (k == 513), retry: 2'(k >= 513), abort: 1'b0});
            cyc(ACT);
            e = qd.pop_front();
            total++; if (cntd !== e.cnt || puld !== e.pulse) $display("FAIL legacy_k%0d got %0d/%b want %0d/%b", k, cntd, puld, e.cnt, e.pulse); else passed++;
        end
        total++; if (totd !== 16'd1 || rtd !== 2'd1) $display("FAIL legacy_total got %0d/%0d want 1/1", totd, rtd); else passed++;
    endtask

    task automatic test_idle;
        cyc(IDLE);
        total++; if (cnt0 !== 16'd0 || rt0 !== 2'd0) $display("FAIL idle_clear got %0d/%0d want 0/0", cnt0, rt0); else passed++;
        total++; if (stk0 !== 1'b1 || ab0 !== 1'b1) $display("FAIL idle_keeps_sticky got %b/%b want 1/1", stk0, ab0); else passed++;
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_hold_exit();
        test_ack_te();
        test_change_at_limit();
        test_enable();
        test_default();
        test_idle();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
